// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the BCD conversion arbiter.
// The default requester count lives here so that all users agree on it.
package bcd_arb_pkg;

    localparam int BIN_W         = 4;
    localparam int BCD_W         = 8;
    localparam int DEFAULT_N_REQ = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/BCD.sv
// Combinational 4-bit binary to two-digit BCD converter.
// The result is {tens, ones}. The tens digit can only be 0 or 1.
module BCD
    import bcd_arb_pkg::*;
(
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd
);

    always_comb begin
        if (bin > 4'd9) bcd = {4'd1, bin - 4'd10};
        else            bcd = {4'd0, bin};
    end

endmodule

// File: rtl/rr_pick.sv
// Round-robin winner search, purely combinational.
// The search starts one position after last_grant and wraps modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any_valid
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant     = '0;
        idx       = '0;
        found     = 1'b0;
        cand      = '0;
        any_valid = |valid;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % N_REQ);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one BCD converter among N_REQ requesters through round-robin arbitration.
// The converted byte goes into a one-entry output register that holds under backpressure.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int STALL_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [BIN_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BCD_W-1:0]       out_data,
    output logic [ID_W-1:0]        out_id,
    output logic [STALL_W-1:0]     stall_cnt,
    output logic                   busy
);

    state_t             state, state_nxt;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    win_idx;
    logic [N_REQ-1:0]   win_onehot;
    logic               any_valid;
    logic               accept;
    logic               fire;
    logic [BIN_W-1:0]   win_data;
    logic [BCD_W-1:0]   win_bcd;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (win_onehot),
        .idx        (win_idx),
        .any_valid  (any_valid)
    );

    assign win_data = req_data[BIN_W*win_idx +: BIN_W];

    BCD u_bcd (
        .bin (win_data),
        .bcd (win_bcd)
    );

    // The output register can take a new result whenever the current one leaves this cycle.
    assign out_valid = (state != EMPTY);
    assign accept    = !out_valid || out_ready;
    assign fire      = !rst && accept && any_valid;
    assign req_ready = fire ? win_onehot : '0;
    assign busy      = out_valid || (|req_valid);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:       if (fire) state_nxt = FULL;
            FULL, STALL: begin
                if (!out_ready) state_nxt = STALL;
                else if (fire)  state_nxt = FULL;
                else            state_nxt = EMPTY;
            end
            default:     state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
        end else begin
            state      <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_id     <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else if (fire) begin
            out_data   <= win_bcd;
            out_id     <= win_idx;
            last_grant <= win_idx;
        end
    end

    // Counts consecutive blocked cycles. It saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || !out_valid || out_ready) begin
            stall_cnt <= '0;
        end else if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter with N_REQ=4.
// A reference model tracks the pointer, output occupancy and stall count.
module tb_bcd_conv_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [4*N-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [IW-1:0] out_id;
    logic [7:0]    stall_cnt;
    logic          busy;

    bcd_conv_arbiter #(.N_REQ(N), .ID_W(IW), .STALL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .stall_cnt (stall_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    logic [9:0] q[$];
    int         m_ptr;
    logic       m_ov;
    int         m_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd_ref(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic drive(input logic [3:0] v, input logic [15:0] d, input logic r);
        req_valid = v;
        req_data  = d;
        out_ready = r;
        #3;
    endtask

    // Compares the DUT against the model, then advances both across one clock edge.
    task automatic step();
        int         w;
        logic       acc;
        logic       fire;
        logic [3:0] exp_rdy;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("busy", 32'(busy), 32'(m_ov || (|req_valid)));
        acc = !m_ov || out_ready;
        w   = -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (w < 0 && req_valid[c]) w = c;
        end
        fire    = acc && (w >= 0);
        exp_rdy = fire ? 4'(1 << w) : 4'b0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (m_ov && q.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(q[0][7:0]));
            chk("out_id", 32'(out_id), 32'(q[0][9:8]));
            if (out_ready) void'(q.pop_front());
        end
        if (fire) begin
            q.push_back({2'(w), bcd_ref(int'(req_data[4*w +: 4]))});
            m_ptr = w;
        end
        if (m_ov && !out_ready) m_stall = (m_stall == 255) ? 255 : m_stall + 1;
        else                    m_stall = 0;
        m_ov = fire || (m_ov && !out_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input logic [3:0] v);
        rst       = 1'b1;
        req_valid = v;
        req_data  = 16'hFFFF;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #3;
            chk("rst_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        m_ptr   = N - 1;
        m_ov    = 1'b0;
        m_stall = 0;
        q.delete();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
    endtask

    logic [7:0] exp_seq [4] = '{8'h09, 8'h10, 8'h11, 8'h12};
    logic [3:0] skip_seq[4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset with every requester asking; requester 0 wins first.
        do_reset(2, 4'hF);
        drive(4'hF, 16'h3210, 1'b1);
        chk("first_grant", 32'(req_ready), 32'b0001);
        step();
        drive(4'h0, 16'h0, 1'b1);
        step();

        // A single request from requester 2 carrying 13.
        drive(4'b0100, 16'h0D00, 1'b1);
        chk("single_ready", 32'(req_ready), 32'b0100);
        step();
        drive(4'h0, 16'h0, 1'b1);
        chk("single_data", 32'(out_data), 32'h13);
        chk("single_id", 32'(out_id), 32'd2);
        step();

        // Full contention with values 9..12 and no bubbles.
        do_reset(1, 4'h0);
        for (int i = 0; i < 5; i++) begin
            drive(4'hF, 16'hCBA9, 1'b1);
            chk("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
            if (i > 0) chk("rr_data", 32'(out_data), 32'(exp_seq[(i-1) % 4]));
            step();
        end

        // Backpressure: the 09 result from requester 0 must hold.
        for (int i = 0; i < 5; i++) begin
            drive(4'hF, 16'hCBA9, 1'b0);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_data", 32'(out_data), 32'h09);
            chk("bp_id", 32'(out_id), 32'd0);
            step();
        end
        drive(4'hF, 16'hCBA9, 1'b1);
        chk("bp_stall5", 32'(stall_cnt), 32'd5);
        chk("bp_regrant", 32'(req_ready), 32'b0010);
        step();
        drive(4'h0, 16'hCBA9, 1'b1);
        chk("bp_clear", 32'(stall_cnt), 32'd0);
        chk("bp_next_data", 32'(out_data), 32'h10);
        chk("bp_next_id", 32'(out_id), 32'd1);
        step();

        // Only requesters 1 and 3 ask after a grant to 1.
        for (int i = 0; i < 4; i++) begin
            drive(4'b1010, 16'h5F4E, 1'b1);
            chk("skip_grant", 32'(req_ready), 32'(skip_seq[i]));
            step();
        end
        drive(4'h0, 16'h0, 1'b1);
        step();

        // Reset while stalled drops the held result and restores the pointer.
        drive(4'b0100, 16'h0700, 1'b1);
        step();
        drive(4'h0, 16'h0, 1'b0);
        step();
        step();
        do_reset(1, 4'hF);
        drive(4'hF, 16'h8642, 1'b1);
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        step();
        drive(4'h0, 16'h0, 1'b1);
        step();

        // Stall counter saturation.
        drive(4'b0001, 16'h000F, 1'b1);
        step();
        for (int i = 0; i < 260; i++) begin
            drive(4'h0, 16'h0, 1'b0);
            step();
        end
        drive(4'h0, 16'h0, 1'b1);
        chk("stall_sat", 32'(stall_cnt), 32'd255);
        step();
        step();

        // Random traffic checked only by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(4'h0, 16'h0, 1'b1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
